// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and state encoding for the multi-cycle RV32 control sequencer.
// Used by multicycle_ctrl_fsm and its testbench.
package riscv_ctrl_pkg;

    // Opcode field IR[6:0] of the supported instruction classes
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU operation select driven to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_EXEC   = 4'd2,
        ST_ALUWB  = 4'd3,
        ST_ADDR   = 4'd4,
        ST_MEMRD  = 4'd5,
        ST_LDWB   = 4'd6,
        ST_MEMWR  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_HALT   = 4'd9
    } ctrl_state_t;

    // States that finish an instruction when they fall back to FETCH
    function automatic logic is_retire_state(input ctrl_state_t st);
        return (st == ST_ALUWB) || (st == ST_LDWB) ||
               (st == ST_MEMWR) || (st == ST_BRANCH);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state watchdog.
// Down-counter loaded with MEM_WAIT_MAX whenever no access is stalled and
// decremented on every stalled cycle. o_expired flags that the current cycle
// is the MEM_WAIT_MAX-th cycle of the access: a ready in this cycle is still
// accepted, a stall in this cycle is a bus error.
module mem_wait_timer #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_expired
);

    localparam int unsigned W = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(MEM_WAIT_MAX);

    logic [W-1:0] r_remain;

    // Reload on clear, otherwise count down once per stalled cycle (saturating)
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_remain <= LOAD_VAL;
        end else if (i_count && (r_remain != '0)) begin
            r_remain <= r_remain - 1'b1;
        end
    end

    assign o_expired = (r_remain == W'(1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencer for the RV32 subset datapath (R, I-ALU, LW, SW, BEQ).
// Drives the shared ALU, register file and unified memory port; handles
// memory wait states with a timeout, and halts on illegal opcodes/bus errors.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined;
// otherwise cycle_count and instr_count are tied to zero.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  FETCH     | idle when !run; else read IR from memory at PC, PC+4 on ready
//  DECODE    | register read, dispatch on opcode
//  EXEC      | R/I ALU operation
//  ALUWB     | write ALU result to rd, retire
//  ADDR      | effective address = rs1 + imm
//  MEMRD     | load access at ALUOut, wait for ready
//  LDWB      | write MDR to rd, retire
//  MEMWR     | store access at ALUOut, wait for ready, retire
//  BRANCH    | compare rs1/rs2, conditional PC update, retire
//  HALT      | illegal opcode or bus error; left only through reset
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             ALUSrc,
    output logic [1:0]       ALUOp,
    output logic             IllegalInstr,
    output logic             BusError,
    output logic             Halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    ctrl_state_t r_state;
    ctrl_state_t w_state_next;
    logic        r_illegal;
    logic        r_bus_err;
    logic        w_set_illegal;
    logic        w_set_bus_err;
    logic        w_mem_active;
    logic        w_mem_wait;
    logic        w_timer_expired;

    // Stalled access: a memory state is driving a request and memory is not ready
    assign w_mem_wait = w_mem_active & ~mem_ready;

    // The timer is held at full count except while an access is stalled, so it is
    // always fresh on entry to FETCH/MEMRD/MEMWR.
    mem_wait_timer #(
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) u_mem_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (~w_mem_wait),
        .i_count   (w_mem_wait),
        .o_expired (w_timer_expired)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_bus_err) r_bus_err <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next  = r_state;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;
        w_mem_active  = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (run) begin
                    w_mem_active = 1'b1;
                    if (mem_ready) begin
                        w_state_next = ST_DECODE;
                    end else if (w_timer_expired) begin
                        w_set_bus_err = 1'b1;
                        w_state_next  = ST_HALT;
                    end
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE, OP_ITYPE: w_state_next = ST_EXEC;
                    OP_LOAD, OP_STORE:  w_state_next = ST_ADDR;
                    OP_BRANCH:          w_state_next = ST_BRANCH;
                    default: begin
                        w_set_illegal = 1'b1;
                        w_state_next  = ST_HALT;
                    end
                endcase
            end
            ST_EXEC:   w_state_next = ST_ALUWB;
            ST_ALUWB:  w_state_next = ST_FETCH;
            ST_ADDR:   w_state_next = (opcode == OP_LOAD) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                w_mem_active = 1'b1;
                if (mem_ready) begin
                    w_state_next = ST_LDWB;
                end else if (w_timer_expired) begin
                    w_set_bus_err = 1'b1;
                    w_state_next  = ST_HALT;
                end
            end
            ST_LDWB:   w_state_next = ST_FETCH;
            ST_MEMWR: begin
                w_mem_active = 1'b1;
                if (mem_ready) begin
                    w_state_next = ST_FETCH;
                end else if (w_timer_expired) begin
                    w_set_bus_err = 1'b1;
                    w_state_next  = ST_HALT;
                end
            end
            ST_BRANCH: w_state_next = ST_FETCH;
            ST_HALT:   w_state_next = ST_HALT;
            // Unused encodings fall back to a clean instruction boundary
            default:   w_state_next = ST_FETCH;
        endcase
    end

    // Output decode; everything is forced low while reset is held
    always_comb begin
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        MemToReg     = 1'b0;
        ALUSrc       = 1'b0;
        ALUOp        = ALUOP_ADD;
        IllegalInstr = 1'b0;
        BusError     = 1'b0;
        Halted       = 1'b0;
        if (!reset) begin
            IllegalInstr = r_illegal;
            BusError     = r_bus_err;
            case (r_state)
                ST_FETCH: begin
                    if (run) begin
                        MemRead = 1'b1;
                        IorD    = 1'b0;
                        if (mem_ready) begin
                            IRWrite = 1'b1;
                            PCWrite = 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    if (opcode == OP_ITYPE) begin
                        ALUSrc = 1'b1;
                        ALUOp  = ALUOP_ADD;
                    end else begin
                        ALUSrc = 1'b0;
                        ALUOp  = ALUOP_FUNCT;
                    end
                end
                ST_ALUWB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b0;
                end
                ST_ADDR: begin
                    ALUSrc = 1'b1;
                    ALUOp  = ALUOP_ADD;
                end
                ST_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                ST_LDWB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                ST_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                ST_BRANCH: begin
                    ALUSrc      = 1'b0;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                end
                ST_HALT:  Halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_instr_count;
    logic             w_retire;

    assign w_retire = is_retire_state(r_state) && (w_state_next == ST_FETCH);

    // Free-running performance counters, wrapping at 2^CNT_W, frozen in HALT
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            if (r_state != ST_HALT) r_cycle_count <= r_cycle_count + 1'b1;
            if (w_retire)           r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign cycle_count = reset ? '0 : r_cycle_count;
    assign instr_count = reset ? '0 : r_instr_count;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench for multicycle_ctrl_fsm.
// Each cycle the expected control vector is queued when inputs are driven and
// popped/compared against the DUT at the following falling edge.
module tb_multicycle_ctrl_fsm;
    import riscv_ctrl_pkg::*;

    localparam int CNT_W = 32;

    // Expected-vector bit layout:
    // 13 PCWrite 12 PCWriteCond 11 IorD 10 IRWrite 9 MemRead 8 MemWrite 7 RegWrite
    //  6 MemToReg 5 ALUSrc 4:3 ALUOp 2 IllegalInstr 1 BusError 0 Halted
    localparam logic [13:0] Z       = 14'h0000;
    localparam logic [13:0] B_PCW   = 14'h2000;
    localparam logic [13:0] B_PCWC  = 14'h1000;
    localparam logic [13:0] B_IORD  = 14'h0800;
    localparam logic [13:0] B_IRW   = 14'h0400;
    localparam logic [13:0] B_MRD   = 14'h0200;
    localparam logic [13:0] B_MWR   = 14'h0100;
    localparam logic [13:0] B_RW    = 14'h0080;
    localparam logic [13:0] B_M2R   = 14'h0040;
    localparam logic [13:0] B_ASRC  = 14'h0020;
    localparam logic [13:0] B_ASUB  = 14'h0008;
    localparam logic [13:0] B_AFUN  = 14'h0010;
    localparam logic [13:0] B_ILL   = 14'h0004;
    localparam logic [13:0] B_BERR  = 14'h0002;
    localparam logic [13:0] B_HALT  = 14'h0001;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite;
    logic             RegWrite, MemToReg, ALUSrc, IllegalInstr, BusError, Halted;
    logic [1:0]       ALUOp;
    logic [CNT_W-1:0] cycle_count, instr_count;
    logic [13:0]      obs;

    logic             cur_rst;
    logic             cur_run;
    logic [6:0]       cur_op;
    logic [13:0]      exp_q[$];
    int               total = 0;
    int               bad   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(
        .MEM_WAIT_MAX (15),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .PCWrite      (PCWrite),
        .PCWriteCond  (PCWriteCond),
        .IorD         (IorD),
        .IRWrite      (IRWrite),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .RegWrite     (RegWrite),
        .MemToReg     (MemToReg),
        .ALUSrc       (ALUSrc),
        .ALUOp        (ALUOp),
        .IllegalInstr (IllegalInstr),
        .BusError     (BusError),
        .Halted       (Halted),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
    );

    assign obs = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, RegWrite,
                  MemToReg, ALUSrc, ALUOp, IllegalInstr, BusError, Halted};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs after the rising edge, queue the expectation,
    // compare at the falling edge.
    task automatic cyc(input string tag, input logic rdy, input logic [13:0] exp);
        @(posedge clk);
        #1;
        reset     = cur_rst;
        run       = cur_run;
        opcode    = cur_op;
        mem_ready = rdy;
        exp_q.push_back(exp);
        @(negedge clk);
        check(tag, {50'd0, obs}, {50'd0, exp_q.pop_front()});
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic fetch(input int waits);
        for (int k = 0; k < waits; k++) cyc("fetch_wait", 1'b0, B_MRD);
        cyc("fetch", 1'b1, B_MRD | B_IRW | B_PCW);
    endtask

    // Expected control sequence for one complete instruction
    task automatic instr(input logic [6:0] op, input int fetch_waits, input int mem_waits);
        cur_op = op;
        fetch(fetch_waits);
        cyc("decode", rnd_bit(), Z);
        case (op)
            OP_RTYPE: begin
                cyc("exec_r", rnd_bit(), B_AFUN);
                cyc("aluwb_r", rnd_bit(), B_RW);
            end
            OP_ITYPE: begin
                cyc("exec_i", rnd_bit(), B_ASRC);
                cyc("aluwb_i", rnd_bit(), B_RW);
            end
            OP_LOAD: begin
                cyc("addr_lw", rnd_bit(), B_ASRC);
                for (int k = 0; k < mem_waits; k++) cyc("memrd_wait", 1'b0, B_MRD | B_IORD);
                cyc("memrd", 1'b1, B_MRD | B_IORD);
                cyc("ldwb", rnd_bit(), B_RW | B_M2R);
            end
            OP_STORE: begin
                cyc("addr_sw", rnd_bit(), B_ASRC);
                for (int k = 0; k < mem_waits; k++) cyc("memwr_wait", 1'b0, B_MWR | B_IORD);
                cyc("memwr", 1'b1, B_MWR | B_IORD);
            end
            default: begin
                cyc("branch", rnd_bit(), B_ASUB | B_PCWC);
            end
        endcase
    endtask

    initial begin
        cur_rst   = 1'b1;
        cur_run   = 1'b0;
        cur_op    = 7'd0;
        reset     = 1'b1;
        run       = 1'b0;
        opcode    = 7'd0;
        mem_ready = 1'b0;

        // Reset state
        cyc("reset", 1'b1, Z);
        cur_run = 1'b1;
        cyc("reset_run", 1'b1, Z);
        check("cycle_cnt_rst", cycle_count, 0);
        check("instr_cnt_rst", instr_count, 0);
        cur_rst = 1'b0;

        // Zero-wait instructions of each class
        instr(OP_RTYPE, 0, 0);
        instr(OP_ITYPE, 0, 0);
        instr(OP_BRANCH, 0, 0);

        // Idle with run low
        cur_run = 1'b0;
        for (int k = 0; k < 3; k++) cyc("idle", rnd_bit(), Z);
        cur_run = 1'b1;

        // Memory instructions with wait states
        instr(OP_LOAD, 0, 3);
        instr(OP_STORE, 2, 2);
        instr(OP_LOAD, 1, 0);

        // run dropped mid-instruction only takes effect back in FETCH
        cur_op = OP_RTYPE;
        fetch(0);
        cur_run = 1'b0;
        cyc("decode_norun", 1'b1, Z);
        cyc("exec_norun", 1'b1, B_AFUN);
        cyc("aluwb_norun", 1'b1, B_RW);
        cyc("idle_after_drop", 1'b1, Z);
        cur_run = 1'b1;

        // Ready on the 15th fetch cycle is still accepted
        instr(OP_ITYPE, 14, 0);
        // Ready on the 15th memory cycle is still accepted
        instr(OP_STORE, 0, 14);

        // Illegal opcode halts after DECODE with no memory requests
        cur_op = 7'b1111111;
        fetch(0);
        cyc("decode_illegal", 1'b1, Z);
        for (int k = 0; k < 4; k++) cyc("halt_illegal", 1'b1, B_ILL | B_HALT);
        cur_rst = 1'b1;
        cyc("reset_after_illegal", 1'b1, Z);
        cur_rst = 1'b0;
        instr(OP_RTYPE, 0, 0);

        // Fetch timeout: 15 stalled cycles raise BusError
        cur_op = OP_RTYPE;
        for (int k = 0; k < 15; k++) cyc("fetch_stall", 1'b0, B_MRD);
        for (int k = 0; k < 3; k++) cyc("halt_berr", 1'b1, B_BERR | B_HALT);
        cur_rst = 1'b1;
        cyc("reset_after_berr", 1'b1, Z);
        cur_rst = 1'b0;

        // Load timeout in MEMRD
        cur_op = OP_LOAD;
        fetch(0);
        cyc("decode_lw", 1'b1, Z);
        cyc("addr_lw", 1'b1, B_ASRC);
        for (int k = 0; k < 15; k++) cyc("memrd_stall", 1'b0, B_MRD | B_IORD);
        cyc("halt_berr_rd", 1'b1, B_BERR | B_HALT);
        cur_rst = 1'b1;
        cyc("reset_after_rd", 1'b1, Z);
        cur_rst = 1'b0;

        // Reset during MEMWR aborts the store
        cur_op = OP_STORE;
        fetch(0);
        cyc("decode_sw", 1'b1, Z);
        cyc("addr_sw", 1'b1, B_ASRC);
        cyc("memwr_wait", 1'b0, B_MWR | B_IORD);
        cur_rst = 1'b1;
        cyc("reset_in_memwr", 1'b1, Z);
        cur_rst = 1'b0;
        cur_op  = OP_RTYPE;
        cyc("fetch_after_abort", 1'b0, B_MRD);
        cyc("fetch_after_abort", 1'b1, B_MRD | B_IRW | B_PCW);
        cyc("decode_after_abort", 1'b1, Z);
        cyc("exec_after_abort", 1'b1, B_AFUN);
        cyc("aluwb_after_abort", 1'b1, B_RW);

        // Performance counters over 10 back-to-back R-types
        cur_rst = 1'b1;
        cyc("reset_perf", 1'b1, Z);
        cur_rst = 1'b0;
        for (int n = 0; n < 10; n++) instr(OP_RTYPE, 0, 0);
        @(posedge clk);
        #1;
`ifdef CTRL_PERF_CNT_EN
        check("cycle_count_10r", cycle_count, 40);
        check("instr_count_10r", instr_count, 10);
`else
        check("cycle_count_tied", cycle_count, 0);
        check("instr_count_tied", instr_count, 0);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
